resonator_ddc_div_36s_16ns_18s: RTL and testbench



---
 rtl/resonator_ddc_div_pkg.sv | 28 ++
 rtl/resonator_ddc_div_step.sv | 32 +++
 rtl/resonator_ddc_div_36s_16ns_18s.sv | 145 ++++++++++++++
 tb/tb_resonator_ddc_div_36s_16ns_18s.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/resonator_ddc_div_pkg.sv
// ============================================================================
// Module      : resonator_ddc_div_pkg
// Description : Shared widths, saturation limits and FSM encoding for the
//               DDC signed-by-unsigned divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package resonator_ddc_div_pkg;

  localparam int DIVIDEND_W = 36;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 18;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  localparam logic signed [QUOT_W-1:0] QMAX = 18'sh1FFFF;  //  131071
  localparam logic signed [QUOT_W-1:0] QMIN = 18'sh20000;  // -131072

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/resonator_ddc_div_step.sv
// ============================================================================
// Module      : resonator_ddc_div_step
// Description : One combinational restoring-division step: shift in the next
//               dividend bit and conditionally subtract the divisor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resonator_ddc_div_step
  import resonator_ddc_div_pkg::*;
#(
  parameter int W = DIVISOR_W
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);

  logic [W+1:0] w_sh;
  logic         w_ge;

  // One extra bit keeps the shifted value exact; the result is always < divisor.
  assign w_sh   = {i_rem, i_bit};
  assign w_ge   = (w_sh >= {2'b00, i_div});
  assign o_qbit = w_ge;
  assign o_rem  = w_ge ? (W+1)'(w_sh - {2'b00, i_div}) : w_sh[W:0];

endmodule

`default_nettype wire

// File: rtl/resonator_ddc_div_36s_16ns_18s.sv
// ============================================================================
// Module      : resonator_ddc_div_36s_16ns_18s
// Description : Multi-cycle 36-bit signed / 16-bit unsigned restoring divider
//               with truncation toward zero, saturation and valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resonator_ddc_div_36s_16ns_18s
  import resonator_ddc_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  ovf,
  output logic                  dbz
);

  localparam logic [DIVIDEND_W-1:0] c_POS_LIM = 36'd131071;
  localparam logic [DIVIDEND_W-1:0] c_NEG_LIM = 36'd131072;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_mag;
  logic [DIVISOR_W:0]    r_rem;
  logic [DIVISOR_W-1:0]  r_div;
  logic                  r_neg;
  logic                  r_dbz;

  logic [DIVIDEND_W-1:0] w_abs;
  logic [DIVISOR_W:0]    w_step_rem;
  logic                  w_step_q;
  logic [QUOT_W-1:0]     w_q;
  logic [DIVISOR_W:0]    w_r;
  logic                  w_ovf;

  // -2^35 negates to itself, which read as unsigned is exactly 2^35.
  assign w_abs    = dividend[DIVIDEND_W-1] ? (-dividend) : dividend;
  assign in_ready = (r_state == IDLE);

  resonator_ddc_div_step #(
    .W (DIVISOR_W)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_mag[DIVIDEND_W-1]),
    .i_div  (r_div),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_q)
  );

  // r_mag holds unconsumed dividend bits on top and quotient bits below;
  // after the last step it is the full magnitude quotient.
  always_comb begin
    w_q   = '0;
    w_r   = '0;
    w_ovf = 1'b0;
    if (r_dbz) begin
      w_q = r_neg ? QMIN : QMAX;
    end else if (r_neg) begin
      w_r = -r_rem;
      if (r_mag > c_NEG_LIM) begin
        w_q   = QMIN;
        w_ovf = 1'b1;
      end else begin
        w_q = -r_mag[QUOT_W-1:0];
      end
    end else begin
      w_r = r_rem;
      if (r_mag > c_POS_LIM) begin
        w_q   = QMAX;
        w_ovf = 1'b1;
      end else begin
        w_q = r_mag[QUOT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_neg     <= 1'b0;
      r_dbz     <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mag <= w_abs;
            r_neg <= dividend[DIVIDEND_W-1];
            r_div <= divisor;
            r_dbz <= (divisor == '0);
            r_rem <= '0;
            if (divisor == '0) begin
              r_state <= FIX;
            end else begin
              r_cnt   <= CNT_W'(DIVIDEND_W - 1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_mag <= {r_mag[DIVIDEND_W-2:0], w_step_q};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          quotient  <= w_q;
          remainder <= w_r;
          ovf       <= w_ovf;
          dbz       <= r_dbz;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_resonator_ddc_div_36s_16ns_18s.sv
// ============================================================================
// Module      : tb_resonator_ddc_div_36s_16ns_18s
// Description : Self-checking bench: transaction-level arithmetic model plus
//               directed vectors with hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_resonator_ddc_div_36s_16ns_18s;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [35:0] dividend  = '0;
  logic [15:0] divisor   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [17:0] quotient;
  logic [16:0] remainder;
  logic        ovf;
  logic        dbz;

  resonator_ddc_div_36s_16ns_18s dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint q;
    longint r;
    bit     ovf;
    bit     dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Plain integer arithmetic: SV signed division truncates toward zero and
  // the remainder takes the dividend's sign.
  function automatic exp_t model(input longint a, input longint d);
    exp_t e;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (d == 0) begin
      e.q   = (a < 0) ? -131072 : 131071;
      e.r   = 0;
      e.dbz = 1'b1;
    end else begin
      e.q = a / d;
      e.r = a % d;
      if (e.q > 131071) begin
        e.q   = 131071;
        e.ovf = 1'b1;
      end else if (e.q < -131072) begin
        e.q   = -131072;
        e.ovf = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Model: one outstanding operation; accepted when idle, retired on handoff.
  always @(posedge clk or negedge reset_n) begin
    exp_t dummy;
    if (!reset_n) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (out_valid && out_ready) dummy = exp_q.pop_front();
    end else if (in_valid) begin
      exp_q.push_back(model(longint'($signed(dividend)), longint'(divisor)));
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready", longint'(in_ready), longint'(exp_q.size() == 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("quotient",  longint'($signed(quotient)),  exp_q[0].q);
          chk("remainder", longint'($signed(remainder)), exp_q[0].r);
          chk("ovf",       longint'(ovf),                longint'(exp_q[0].ovf));
          chk("dbz",       longint'(dbz),                longint'(exp_q[0].dbz));
        end
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; lat < 0 marks the
  // divide-by-zero path, whose result must be up within two edges.
  task automatic run_op(input longint a, input longint d, input int lat,
                        input longint eq, input longint er,
                        input bit eovf, input bit edbz);
    int n;
    dividend = 36'(a);
    divisor  = 16'(d);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 36'h5A5A5A5A5;
    divisor  = 16'h1234;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (lat < 0) chk("dbz_latency_le2", longint'(n <= 2), 1);
    else         chk("latency", n, lat);
    chk("lit_quotient",  longint'($signed(quotient)),  eq);
    chk("lit_remainder", longint'($signed(remainder)), er);
    chk("lit_ovf",       longint'(ovf),  longint'(eovf));
    chk("lit_dbz",       longint'(dbz),  longint'(edbz));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  longint'(in_ready),  1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_quotient",  longint'(quotient),  0);
    chk("rst_remainder", longint'(remainder), 0);
    chk("rst_flags",     longint'({ovf, dbz}), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1000, 7, 37, 142, 6, 0, 0);
    run_op(-1000, 7, 37, -142, -6, 0, 0);
    run_op(1048576, 1, 37, 131071, 0, 1, 0);
    run_op(-131072, 1, 37, -131072, 0, 0, 0);
    run_op(-131073, 1, 37, -131072, 0, 1, 0);
    run_op(-5, 0, -1, -131072, 0, 0, 1);
    run_op(5, 0, -1, 131071, 0, 0, 1);
    run_op(0, 3, 37, 0, 0, 0, 0);
    run_op(-123456, 1000, 37, -123, -456, 0, 0);
    run_op(-(64'sd1 <<< 35), 1, 37, -131072, 0, 1, 0);
    run_op((64'sd1 <<< 35) - 1, 65535, 37, 131071, 7, 1, 0);

    // Backpressure: result held, competing operand offered and refused.
    out_ready = 1'b0;
    dividend  = 36'd65535;
    divisor   = 16'd65535;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", n, 37);
    dividend = 36'd77;
    divisor  = 16'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_quotient",  longint'($signed(quotient)),  1);
      chk("bp_remainder", longint'($signed(remainder)), 0);
      chk("bp_in_ready",  longint'(in_ready),  0);
      chk("bp_out_valid", longint'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_in_ready_after", longint'(in_ready),  1);
    chk("bp_out_valid_drop", longint'(out_valid), 0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_offer_not_taken", seen, 0);

    // Reset in the middle of CALC discards the operation.
    dividend = 36'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  longint'(in_ready),  1);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_quotient",  longint'(quotient),  0);
    chk("mid_rst_remainder", longint'(remainder), 0);
    chk("mid_rst_flags",     longint'({ovf, dbz}), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no_out_after_reset", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
